exe_operand_stage: RTL and testbench

Parametrised operand-select and forwarding stage between the ID/EXE pipeline register and the ALU. It picks operand 1 and operand 2 for each instruction: register data, extended immediate, or the store-data register for the MemNew mode. It also forwards results from EX/MEM and MEM/WB and inserts a one-cycle bubble on load-use hazards. The selected operands are registered into a single-entry valid/ready output slot and the stage keeps a saturating stall counter.

---
 rtl/exe_operand_stage_pkg.sv | 22 ++
 rtl/exe_operand_stage_fwd_select.sv | 46 ++++
 rtl/exe_operand_stage.sv | 113 +++++++++++
 tb/tb_exe_operand_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/exe_operand_stage_pkg.sv
// Shared encodings for the operand-select / forwarding stage.
package exe_operand_stage_pkg;

  typedef enum logic [1:0] {
    OP2_REG  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_DREG = 2'd2
  } op2_sel_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_ZERO  = 2'd3
  } fwd_src_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/exe_operand_stage_fwd_select.sv
// Per-source forwarding selector with load-use hazard detection.
module fwd_select
  import exe_operand_stage_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  needed,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  exmem_wr_en,
  input  logic [REG_ADDR_W-1:0] exmem_wr_addr,
  input  logic [DATA_W-1:0]     exmem_wr_data,
  input  logic                  exmem_is_load,
  input  logic                  memwb_wr_en,
  input  logic [REG_ADDR_W-1:0] memwb_wr_addr,
  input  logic [DATA_W-1:0]     memwb_wr_data,
  output logic [DATA_W-1:0]     data,
  output logic                  hazard
);

  fwd_src_e src;
  logic     exmem_hit;

  always_comb begin
    exmem_hit = exmem_wr_en && (exmem_wr_addr == addr);
    src       = FWD_RF;
    if (addr == '0)
      src = FWD_ZERO;
    else if (exmem_hit && !exmem_is_load)
      src = FWD_EXMEM;
    else if (memwb_wr_en && (memwb_wr_addr == addr))
      src = FWD_MEMWB;

    unique case (src)
      FWD_ZERO:  data = '0;
      FWD_EXMEM: data = exmem_wr_data;
      FWD_MEMWB: data = memwb_wr_data;
      default:   data = rf_data;
    endcase

    // A pending load to a live source must wait one cycle to reach MEM/WB.
    hazard = needed && (addr != '0) && exmem_hit && exmem_is_load;
  end

endmodule

// File: rtl/exe_operand_stage.sv
// Operand select + forwarding stage with single-entry output slot and stall counter.
module exe_operand_stage
  import exe_operand_stage_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs_addr,
  input  logic [REG_ADDR_W-1:0] in_rt_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0]     in_rs_data,
  input  logic [DATA_W-1:0]     in_rt_data,
  input  logic [DATA_W-1:0]     in_rd_data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_alu_src,
  input  logic                  in_mem_new,
  input  logic                  exmem_wr_en,
  input  logic [REG_ADDR_W-1:0] exmem_wr_addr,
  input  logic [DATA_W-1:0]     exmem_wr_data,
  input  logic                  exmem_is_load,
  input  logic                  memwb_wr_en,
  input  logic [REG_ADDR_W-1:0] memwb_wr_addr,
  input  logic [DATA_W-1:0]     memwb_wr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_op1,
  output logic [DATA_W-1:0]     out_op2,
  output logic                  hazard_stall,
  output logic [CNT_W-1:0]      stall_count
);

  slot_state_e       state, next_state;
  op2_sel_e          op2_sel;
  logic [DATA_W-1:0] rs_fwd, rt_fwd, rd_fwd, op2_next;
  logic              rs_hz, rt_hz, rd_hz;
  logic              need_rt, need_rd, capture;

  assign need_rt = !in_mem_new && !in_alu_src;
  assign need_rd = in_mem_new;

  fwd_select #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .needed(1'b1), .addr(in_rs_addr), .rf_data(in_rs_data),
    .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
    .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
    .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
    .memwb_wr_data(memwb_wr_data), .data(rs_fwd), .hazard(rs_hz)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .needed(need_rt), .addr(in_rt_addr), .rf_data(in_rt_data),
    .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
    .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
    .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
    .memwb_wr_data(memwb_wr_data), .data(rt_fwd), .hazard(rt_hz)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rd (
    .needed(need_rd), .addr(in_rd_addr), .rf_data(in_rd_data),
    .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
    .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
    .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
    .memwb_wr_data(memwb_wr_data), .data(rd_fwd), .hazard(rd_hz)
  );

  always_comb begin
    op2_sel = OP2_REG;
    if (in_mem_new)
      op2_sel = OP2_DREG;
    else if (in_alu_src)
      op2_sel = OP2_IMM;

    unique case (op2_sel)
      OP2_DREG: op2_next = rd_fwd;
      OP2_IMM:  op2_next = in_imm;
      default:  op2_next = rt_fwd;
    endcase
  end

  always_comb begin
    hazard_stall = in_valid && (rs_hz || rt_hz || rd_hz);
    out_valid    = (state == FULL);
    in_ready     = !hazard_stall && (!out_valid || out_ready);
    capture      = in_valid && in_ready;
    next_state   = state;
    if (capture)
      next_state = FULL;
    else if (out_valid && out_ready)
      next_state = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      out_op1     <= '0;
      out_op2     <= '0;
      stall_count <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        out_op1 <= rs_fwd;
        out_op2 <= op2_next;
      end
      if (hazard_stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed scoreboard bench for exe_operand_stage (default and CNT_W=2 instances).
module tb_exe_operand_stage;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_alu_src, in_mem_new, out_ready;
  logic [AW-1:0] in_rs_addr, in_rt_addr, in_rd_addr;
  logic [DW-1:0] in_rs_data, in_rt_data, in_rd_data, in_imm;
  logic          exmem_wr_en, exmem_is_load, memwb_wr_en;
  logic [AW-1:0] exmem_wr_addr, memwb_wr_addr;
  logic [DW-1:0] exmem_wr_data, memwb_wr_data;

  logic          in_ready, out_valid, hazard_stall;
  logic [DW-1:0] out_op1, out_op2;
  logic [15:0]   stall_count;
  logic          in_ready2, out_valid2, hazard_stall2;
  logic [DW-1:0] out_op1_2, out_op2_2;
  logic [1:0]    stall_count2;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [2*DW-1:0] exp_q[$];
  int unsigned     mdl_count = 0;

  always #5 clk = ~clk;

  exe_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_rd_data(in_rd_data),
    .in_imm(in_imm), .in_alu_src(in_alu_src), .in_mem_new(in_mem_new),
    .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
    .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
    .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
    .memwb_wr_data(memwb_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .hazard_stall(hazard_stall),
    .stall_count(stall_count)
  );

  exe_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_rd_data(in_rd_data),
    .in_imm(in_imm), .in_alu_src(in_alu_src), .in_mem_new(in_mem_new),
    .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
    .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
    .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
    .memwb_wr_data(memwb_wr_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_op1(out_op1_2), .out_op2(out_op2_2), .hazard_stall(hazard_stall2),
    .stall_count(stall_count2)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mdl_fwd(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    if (a == 0) return '0;
    if (exmem_wr_en && exmem_wr_addr == a && !exmem_is_load) return exmem_wr_data;
    if (memwb_wr_en && memwb_wr_addr == a) return memwb_wr_data;
    return rf;
  endfunction

  function automatic bit load_hit(input bit need, input logic [AW-1:0] a);
    return need && a != 0 && exmem_wr_en && exmem_is_load && exmem_wr_addr == a;
  endfunction

  task automatic cycle();
    bit hz, rdy, cap;
    logic [DW-1:0] e1, e2;
    #1;
    hz = in_valid && (load_hit(1'b1, in_rs_addr) ||
                      load_hit(!in_mem_new && !in_alu_src, in_rt_addr) ||
                      load_hit(in_mem_new, in_rd_addr));
    rdy = !hz && (exp_q.size() == 0 || out_ready);
    cap = in_valid && rdy;
    e1 = mdl_fwd(in_rs_addr, in_rs_data);
    e2 = in_mem_new ? mdl_fwd(in_rd_addr, in_rd_data) :
         in_alu_src ? in_imm : mdl_fwd(in_rt_addr, in_rt_data);
    if (!rst) begin
      check("hazard_stall", DW'(hazard_stall), DW'(hz));
      check("in_ready", DW'(in_ready), DW'(rdy));
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      mdl_count = 0;
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (cap) exp_q.push_back({e1, e2});
      if (hz && mdl_count < 65535) mdl_count++;
    end
    #1;
    check("out_valid", DW'(out_valid), DW'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_op1", out_op1, exp_q[0][2*DW-1:DW]);
      check("out_op2", out_op2, exp_q[0][DW-1:0]);
    end
    check("stall_count", DW'(stall_count), DW'(mdl_count));
    check("stall_count_sat", DW'(stall_count2), DW'(mdl_count > 3 ? 3 : mdl_count));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_rs_addr = 5'd1; in_rt_addr = 5'd2; in_rd_addr = 5'd3;
    in_rs_data = 64'd5; in_rt_data = 64'd7; in_rd_data = 64'd9; in_imm = 64'h10;
    in_alu_src = 1'b0; in_mem_new = 1'b0;
    exmem_wr_en = 1'b0; exmem_wr_addr = '0; exmem_wr_data = '0; exmem_is_load = 1'b0;
    memwb_wr_en = 1'b0; memwb_wr_addr = '0; memwb_wr_data = '0;
    cycle(); cycle();
    check("reset_op1", out_op1, '0);
    check("reset_op2", out_op2, '0);
    rst = 1'b0;

    // Basic register operands
    in_valid = 1'b1; cycle();
    in_valid = 1'b0; cycle();

    // Forwarding priority
    in_valid = 1'b1; in_rs_addr = 5'd3; in_rs_data = 64'h11;
    exmem_wr_en = 1'b1; exmem_wr_addr = 5'd3; exmem_wr_data = 64'hAA;
    memwb_wr_en = 1'b1; memwb_wr_addr = 5'd3; memwb_wr_data = 64'hBB;
    cycle();
    exmem_wr_en = 1'b0; cycle();
    in_rs_addr = 5'd0; in_rs_data = 64'h99; exmem_wr_en = 1'b1; exmem_wr_addr = 5'd0;
    memwb_wr_en = 1'b0; cycle();

    // Load-use hazard on rt, then resolved through MEM/WB
    in_rs_addr = 5'd1; in_rs_data = 64'd5; in_rt_addr = 5'd4; in_rt_data = 64'h77;
    exmem_wr_en = 1'b1; exmem_wr_addr = 5'd4; exmem_is_load = 1'b1; exmem_wr_data = 64'hDEAD;
    cycle();
    exmem_wr_en = 1'b0; memwb_wr_en = 1'b1; memwb_wr_addr = 5'd4; memwb_wr_data = 64'h1234;
    cycle();
    exmem_wr_en = 1'b1; memwb_wr_en = 1'b0; in_alu_src = 1'b1; in_imm = 64'h42;
    cycle();

    // Dreg over immediate, then immediate
    exmem_wr_en = 1'b0; exmem_is_load = 1'b0;
    in_mem_new = 1'b1; in_rd_addr = 5'd6; in_rd_data = 64'h66;
    memwb_wr_en = 1'b1; memwb_wr_addr = 5'd6; memwb_wr_data = 64'h55;
    cycle();
    in_mem_new = 1'b0; in_imm = 64'hFFFF_FFFF_FFFF_FFF0; cycle();

    // Back-pressure: hold, then consume+capture together
    out_ready = 1'b0; in_imm = 64'h1; cycle();
    in_imm = 64'h2; cycle(); cycle(); cycle();
    out_ready = 1'b1; in_imm = 64'h3; cycle();
    in_valid = 1'b0; cycle();

    // Reset while stalled behind a full slot and a pending load
    in_valid = 1'b1; out_ready = 1'b0; cycle();
    exmem_wr_en = 1'b1; exmem_wr_addr = 5'd1; exmem_is_load = 1'b1; cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; in_valid = 1'b0; exmem_wr_en = 1'b0; cycle();

    // Five consecutive hazard cycles
    in_valid = 1'b1; out_ready = 1'b1; exmem_wr_en = 1'b1;
    repeat (5) cycle();
    exmem_wr_en = 1'b0; cycle();
    in_valid = 1'b0; cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
